// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states, then a held response.
// Optional misalignment trapping is enabled with `define DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                commit;

  logic [31:0]         mem [2**ADDR_W];

  logic                a_we;
  logic [1:0]          a_size;
  logic [ADDR_W+1:0]   a_addr;
  logic [31:0]         a_wdata;
  logic [ADDR_W-1:0]   idx;
  logic [1:0]          off;
  logic                misal;
  logic [31:0]         old_w, new_w, ld_w;
  logic                unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so use the live request.
  always_comb begin
    a_we    = (state_q == S_IDLE) ? req_we    : we_q;
    a_size  = (state_q == S_IDLE) ? req_size  : size_q;
    a_addr  = (state_q == S_IDLE) ? req_addr[ADDR_W+1:0] : addr_q;
    a_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    idx     = a_addr[ADDR_W+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    misal   = ((a_size == 2'b01) && a_addr[0]) || (a_size[1] && (a_addr[1:0] != 2'b00));
    off     = a_addr[1:0];
`else
    misal   = 1'b0;
    case (a_size)
      2'b00:   off = a_addr[1:0];
      2'b01:   off = {a_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
  end

  always_comb begin
    old_w = mem[idx];
    new_w = old_w;
    case (a_size)
      2'b00: begin
        new_w[{off, 3'b000} +: 8] = a_wdata[7:0];
        ld_w = {24'b0, old_w[{off, 3'b000} +: 8]};
      end
      2'b01: begin
        new_w[{off[1], 4'b0000} +: 16] = a_wdata[15:0];
        ld_w = {16'b0, old_w[{off[1], 4'b0000} +: 16]};
      end
      default: begin
        new_w = a_wdata;
        ld_w  = old_w;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
      end
      if (commit) rdata_q <= (a_we || misal) ? 32'h0 : ld_w;
    end
  end

  // Array is never reset; a store still waiting when reset hits never reaches it.
  always_ff @(posedge clk) begin
    if (reset && commit && a_we && !misal) mem[idx] <= new_w;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!reset)      err_q <= 1'b0;
    else if (commit) err_q <= misal;
  end
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; four instances cover WAIT_CYCLES = 1, 0, 3, 4.
module tb_dmem_responder;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rv [ND];
  logic        wen [ND];
  logic [1:0]  sz [ND];
  logic [31:0] ad [ND];
  logic [31:0] wd [ND];
  logic        rr [ND];
  logic        rq_rdy [ND];
  logic        rs_v [ND];
  logic [31:0] rs_d [ND];
  logic        rs_e [ND];

  typedef struct packed { logic [31:0] rdata; logic err; } sb_t;
  sb_t sbq [$];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int wc(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 4)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(rv[g]), .req_ready(rq_rdy[g]), .req_we(wen[g]), .req_size(sz[g]),
      .req_addr(ad[g]), .req_wdata(wd[g]),
      .resp_valid(rs_v[g]), .resp_ready(rr[g]), .resp_rdata(rs_d[g]), .resp_err(rs_e[g])
    );
  end

  task automatic do_req(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] wdat, input logic [31:0] er, input logic ee,
                        input int hold, input string nm);
    sb_t e;
    int cyc;
    bit got;
    logic [31:0] snap;
    n_cmp++;
    if (rq_rdy[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s.ready dut%0d: got %b want 1", nm, d, rq_rdy[d]);
    end
    rv[d] = 1'b1; wen[d] = w; sz[d] = s; ad[d] = a; wd[d] = wdat;
    e.rdata = er; e.err = ee;
    sbq.push_back(e);
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      rv[d] = 1'b0; wen[d] = ~w; ad[d] = $urandom; wd[d] = $urandom; sz[d] = 2'($urandom);
      if (rs_v[d] === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got || cyc != wc(d) + 1) begin
      n_fail++;
      $display("FAIL %s.latency dut%0d: got %0d cycles want %0d", nm, d, got ? cyc : -1, wc(d) + 1);
    end
    if (!got) begin
      void'(sbq.pop_front());
      return;
    end
    snap = rs_d[d];
    repeat (hold) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rs_v[d] !== 1'b1 || rs_d[d] !== snap || rq_rdy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s.hold dut%0d: valid=%b rdata=%h ready=%b want 1/%h/0",
                 nm, d, rs_v[d], rs_d[d], rq_rdy[d], snap);
      end
    end
    rr[d] = 1'b1;
    e = sbq.pop_front();
    n_cmp++;
    if (rs_d[d] !== e.rdata) begin
      n_fail++;
      $display("FAIL %s.rdata dut%0d: got %h want %h", nm, d, rs_d[d], e.rdata);
    end
    n_cmp++;
    if (rs_e[d] !== e.err) begin
      n_fail++;
      $display("FAIL %s.err dut%0d: got %b want %b", nm, d, rs_e[d], e.err);
    end
    @(posedge clk); #1;
    rr[d] = 1'b0;
    n_cmp++;
    if (rq_rdy[d] !== 1'b1 || rs_v[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s.return dut%0d: ready=%b valid=%b want 1/0", nm, d, rq_rdy[d], rs_v[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (rq_rdy[d] !== 1'b1 || rs_v[d] !== 1'b0 || rs_d[d] !== 32'h0 || rs_e[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                 d, rq_rdy[d], rs_v[d], rs_d[d], rs_e[d]);
      end
    end
  endtask

  task automatic test_word();
    for (int d = 0; d < 3; d++) begin
      do_req(d, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw");
      do_req(d, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw");
    end
  endtask

  task automatic test_lanes();
    do_req(0, 1'b1, 2'b00, 32'h13, 32'hFFFFFF11, 32'h0, 1'b0, 0, "sb");
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'h11ADBEEF, 1'b0, 0, "lw_sb");
    do_req(0, 1'b0, 2'b00, 32'h12, 32'h0, 32'h000000AD, 1'b0, 0, "lb");
    do_req(0, 1'b1, 2'b01, 32'h10, 32'hFFFF2233, 32'h0, 1'b0, 0, "sh");
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'h11AD2233, 1'b0, 0, "lw_sh");
    do_req(0, 1'b0, 2'b01, 32'h12, 32'h0, 32'h000011AD, 1'b0, 0, "lh");
  endtask

  task automatic test_backpressure();
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'h11AD2233, 1'b0, 5, "bp");
    do_req(2, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, "bp3");
  endtask

  task automatic test_misaligned();
`ifdef DMEM_ALIGN_CHECK_EN
    do_req(0, 1'b1, 2'b10, 32'h11, 32'h12345678, 32'h0, 1'b1, 0, "mis_sw");
    do_req(0, 1'b0, 2'b01, 32'h13, 32'h0, 32'h0, 1'b1, 0, "mis_lh");
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'h11AD2233, 1'b0, 0, "mis_chk");
`else
    do_req(0, 1'b1, 2'b10, 32'h11, 32'h12345678, 32'h0, 1'b0, 0, "mis_sw");
    do_req(0, 1'b0, 2'b01, 32'h13, 32'h0, 32'h00001234, 1'b0, 0, "mis_lh");
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'h12345678, 1'b0, 0, "mis_chk");
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [6];
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 6; i++) begin
        pat[i] = $urandom;
        do_req(d, 1'b1, 2'b10, 32'h40 + 32'(4 * i), pat[i], 32'h0, 1'b0, 0, "b2b_sw");
      end
      for (int i = 0; i < 6; i++)
        do_req(d, 1'b0, 2'b10, 32'h40 + 32'(4 * i), 32'h0, pat[i], 1'b0, 0, "b2b_lw");
    end
  endtask

  task automatic test_reset_midop();
    do_req(3, 1'b1, 2'b10, 32'h20, 32'h01020304, 32'h0, 1'b0, 0, "pre_sw");
    rv[3] = 1'b1; wen[3] = 1'b1; sz[3] = 2'b10; ad[3] = 32'h20; wd[3] = 32'hCAFEF00D;
    @(posedge clk); #1;
    rv[3] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rs_v[3] !== 1'b0 || rq_rdy[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst.idle cyc%0d: valid=%b ready=%b want 0/1", i, rs_v[3], rq_rdy[3]);
      end
      @(posedge clk); #1;
    end
    do_req(3, 1'b0, 2'b10, 32'h20, 32'h0, 32'h01020304, 1'b0, 0, "midrst_lw");
    do_req(3, 1'b0, 2'b10, 32'h20 + 32'(4 * 256), 32'h0, 32'h01020304, 1'b0, 0, "wrap_lw");
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rv[d] = 1'b0; wen[d] = 1'b0; sz[d] = 2'b00; ad[d] = '0; wd[d] = '0; rr[d] = 1'b0;
    end
    test_reset();
    test_word();
    test_lanes();
    test_backpressure();
    test_misaligned();
    test_back_to_back();
    test_reset_midop();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard.drain: %0d left want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
